// File: rtl/sram_param_dp.sv
// sram_param_dp: parametrised simple-dual-port synchronous SRAM model.
// One write port with per-byte enables, one read port, read latency 1 or 2.
// After reset a sequenced clear engine zeroes every word while Busy is high.
// Optional feature macro: SRAM_WR_BYPASS_EN (write-first on same-address
// read/write collisions; read-first when undefined).
module sram_param_dp #(
    parameter int A_WIDTH  = 15,
    parameter int D_WIDTH  = 32,
    parameter int BE_WIDTH = D_WIDTH / 8,
    parameter int RD_LAT   = 1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Wr_En,
    input  logic [A_WIDTH-1:0]  Wr_Addr,
    input  logic [BE_WIDTH-1:0] Wr_Be,
    input  logic [D_WIDTH-1:0]  Wr_Data,
    input  logic                Rd_En,
    input  logic [A_WIDTH-1:0]  Rd_Addr,
    output logic [D_WIDTH-1:0]  Rd_Data,
    output logic                Rd_Valid,
    output logic                Busy
);

    localparam int DEPTH = 2 ** A_WIDTH;

    // Illegal configurations stop elaboration.
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("sram_param_dp: RD_LAT must be 1 or 2");
    end
    if ((D_WIDTH % 8) != 0 || BE_WIDTH != D_WIDTH / 8) begin : g_bad_width
        $error("sram_param_dp: D_WIDTH must be a multiple of 8 and BE_WIDTH = D_WIDTH/8");
    end

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t               state;
    logic [A_WIDTH-1:0]   clr_cnt;
    logic [D_WIDTH-1:0]   mem [DEPTH];

    logic                 vld_p0;
    logic [D_WIDTH-1:0]   rd_word_p0;

`ifdef SRAM_WR_BYPASS_EN
    // Post-write word: enabled bytes from the new data, the rest from the old word.
    function automatic logic [D_WIDTH-1:0] byte_merge(
        input logic [D_WIDTH-1:0]  old_word,
        input logic [D_WIDTH-1:0]  new_word,
        input logic [BE_WIDTH-1:0] be
    );
        logic [D_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction
`endif

    // Clear sequencer: walks every address once after reset, then idles.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            Busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == {A_WIDTH{1'b1}}) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array write: clear engine owns the array while clearing, port writes otherwise.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (Wr_En) begin
                for (int i = 0; i < BE_WIDTH; i++) begin
                    if (Wr_Be[i]) mem[Wr_Addr][8*i +: 8] <= Wr_Data[8*i +: 8];
                end
            end
        end
    end

    // ---- stage p0: request qualification and array lookup ----
    assign vld_p0 = (state == IDLE) && Rd_En;

    // Read word selection; the collision bypass only exists with the macro.
    always_comb begin
        rd_word_p0 = mem[Rd_Addr];
`ifdef SRAM_WR_BYPASS_EN
        if (Wr_En && (Wr_Addr == Rd_Addr)) begin
            rd_word_p0 = byte_merge(mem[Rd_Addr], Wr_Data, Wr_Be);
        end
`endif
    end

    if (RD_LAT == 1) begin : g_lat1
        // ---- stage p1: registered output ----
        // Output register; data forced to zero whenever no result is presented.
        always_ff @(posedge Clk) begin
            if (!Rst) begin
                Rd_Valid <= 1'b0;
                Rd_Data  <= '0;
            end else begin
                Rd_Valid <= vld_p0;
                Rd_Data  <= vld_p0 ? rd_word_p0 : '0;
            end
        end
    end else if (RD_LAT == 2) begin : g_lat2
        logic               vld_p1;
        logic [D_WIDTH-1:0] data_p1;

        // ---- stage p1: capture ----
        // Capture-stage valid; flushed by reset so pending reads are dropped.
        always_ff @(posedge Clk) begin
            if (!Rst) vld_p1 <= 1'b0;
            else      vld_p1 <= vld_p0;
        end

        // Capture-stage data; only meaningful when vld_p1 is set.
        always_ff @(posedge Clk) begin
            data_p1 <= rd_word_p0;
        end

        // ---- stage p2: registered output ----
        // Output register; data forced to zero whenever no result is presented.
        always_ff @(posedge Clk) begin
            if (!Rst) begin
                Rd_Valid <= 1'b0;
                Rd_Data  <= '0;
            end else begin
                Rd_Valid <= vld_p1;
                Rd_Data  <= vld_p1 ? data_p1 : '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_param_dp.sv
// Directed self-checking bench for sram_param_dp (A_WIDTH=4, D_WIDTH=32).
// Two instances share the input stimulus: u1 with RD_LAT=1, u2 with RD_LAT=2.
module tb_sram_param_dp;

    logic        Clk;
    logic        Rst;
    logic        Wr_En;
    logic [3:0]  Wr_Addr;
    logic [3:0]  Wr_Be;
    logic [31:0] Wr_Data;
    logic        Rd_En;
    logic [3:0]  Rd_Addr;
    logic [31:0] Rd_Data1, Rd_Data2;
    logic        Rd_Valid1, Rd_Valid2;
    logic        Busy1, Busy2;

    int total;
    int passed;

    sram_param_dp #(.A_WIDTH(4), .D_WIDTH(32), .RD_LAT(1)) u1 (
        .Clk(Clk), .Rst(Rst), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Be(Wr_Be),
        .Wr_Data(Wr_Data), .Rd_En(Rd_En), .Rd_Addr(Rd_Addr),
        .Rd_Data(Rd_Data1), .Rd_Valid(Rd_Valid1), .Busy(Busy1)
    );

    sram_param_dp #(.A_WIDTH(4), .D_WIDTH(32), .RD_LAT(2)) u2 (
        .Clk(Clk), .Rst(Rst), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Be(Wr_Be),
        .Wr_Data(Wr_Data), .Rd_En(Rd_En), .Rd_Addr(Rd_Addr),
        .Rd_Data(Rd_Data2), .Rd_Valid(Rd_Valid2), .Busy(Busy2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        Wr_En = 1'b1; Wr_Addr = a; Wr_Data = d; Wr_Be = be;
        tick();
        Wr_En = 1'b0;
    endtask

    task automatic test_reset();
        int cnt;
        Rst = 1'b0;
        repeat (3) tick();
        total++;
        if ({Busy1, Busy2, Rd_Valid1, Rd_Valid2} !== 4'b1100) begin
            $display("FAIL reset_ctrl: got busy=%b%b valid=%b%b required busy=11 valid=00",
                     Busy1, Busy2, Rd_Valid1, Rd_Valid2);
        end else passed++;
        total++;
        if ({Rd_Data1, Rd_Data2} !== 64'h0) begin
            $display("FAIL reset_data: got %h/%h required 0/0", Rd_Data1, Rd_Data2);
        end else passed++;

        // Release and hammer both ports while clearing; all must be ignored.
        Rst = 1'b1;
        Wr_En = 1'b1; Wr_Addr = 4'd3; Wr_Data = 32'hFFFF_FFFF; Wr_Be = 4'hF;
        Rd_En = 1'b1; Rd_Addr = 4'd3;
        cnt = 0;
        while (Busy1 === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
            total++;
            if (Rd_Valid1 !== 1'b0 || Rd_Valid2 !== 1'b0) begin
                $display("FAIL busy_gate_valid: cycle %0d got valid=%b%b required 00",
                         cnt, Rd_Valid1, Rd_Valid2);
            end else passed++;
        end
        Wr_En = 1'b0; Rd_En = 1'b0;
        total++;
        if (cnt !== 16) begin
            $display("FAIL clear_len: got %0d cycles required 16", cnt);
        end else passed++;
        total++;
        if (Busy2 !== 1'b0) begin
            $display("FAIL clear_busy2: got %b required 0", Busy2);
        end else passed++;

        // Every word reads back zero, one cycle after the request on u1.
        for (int a = 0; a < 16; a++) begin
            Rd_En = 1'b1; Rd_Addr = 4'(a);
            tick();
            total++;
            if (Rd_Valid1 !== 1'b1 || Rd_Data1 !== 32'h0) begin
                $display("FAIL clear_read addr %0d: got valid=%b data=%h required valid=1 data=00000000",
                         a, Rd_Valid1, Rd_Data1);
            end else passed++;
        end
        Rd_En = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_mid_clear_reset();
        int cnt;
        do_write(4'd3, 32'h1234_5678, 4'hF);
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        repeat (8) tick();
        Rst = 1'b0;
        tick();
        total++;
        if (Busy1 !== 1'b1 || Busy2 !== 1'b1) begin
            $display("FAIL midclear_busy: got %b%b required 11", Busy1, Busy2);
        end else passed++;
        Rst = 1'b1;
        cnt = 0;
        while (Busy1 === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        total++;
        if (cnt !== 16) begin
            $display("FAIL midclear_len: got %0d cycles required 16", cnt);
        end else passed++;
        Rd_En = 1'b1; Rd_Addr = 4'd3;
        tick();
        Rd_En = 1'b0;
        total++;
        if (Rd_Valid1 !== 1'b1 || Rd_Data1 !== 32'h0) begin
            $display("FAIL midclear_addr3: got valid=%b data=%h required valid=1 data=00000000",
                     Rd_Valid1, Rd_Data1);
        end else passed++;
        tick();
        tick();
    endtask

    task automatic test_byte_enables();
        do_write(4'd5, 32'hAABB_CCDD, 4'hF);
        do_write(4'd5, 32'h1122_3344, 4'b0101);
        do_write(4'd5, 32'hFFFF_FFFF, 4'b0000);
        Rd_En = 1'b1; Rd_Addr = 4'd5;
        tick();
        Rd_En = 1'b0;
        total++;
        if (Rd_Valid1 !== 1'b1 || Rd_Data1 !== 32'hAA22_CC44) begin
            $display("FAIL byte_en_lat1: got valid=%b data=%h required valid=1 data=aa22cc44",
                     Rd_Valid1, Rd_Data1);
        end else passed++;
        tick();
        total++;
        if (Rd_Valid2 !== 1'b1 || Rd_Data2 !== 32'hAA22_CC44) begin
            $display("FAIL byte_en_lat2: got valid=%b data=%h required valid=1 data=aa22cc44",
                     Rd_Valid2, Rd_Data2);
        end else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp2 [5];
        logic        expv [5];
        exp2 = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h0};
        expv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_write(4'd1, 32'h1, 4'hF);
        do_write(4'd2, 32'h2, 4'hF);
        do_write(4'd3, 32'h3, 4'hF);
        for (int k = 0; k < 5; k++) begin
            Rd_En = (k < 3); Rd_Addr = 4'(k + 1);
            tick();
            total++;
            if (Rd_Valid2 !== expv[k] || Rd_Data2 !== exp2[k]) begin
                $display("FAIL lat2_seq cycle %0d: got valid=%b data=%h required valid=%b data=%h",
                         k, Rd_Valid2, Rd_Data2, expv[k], exp2[k]);
            end else passed++;
            if (k < 3) begin
                total++;
                if (Rd_Valid1 !== 1'b1 || Rd_Data1 !== 32'(k + 1)) begin
                    $display("FAIL lat1_seq cycle %0d: got valid=%b data=%h required valid=1 data=%h",
                             k, Rd_Valid1, Rd_Data1, 32'(k + 1));
                end else passed++;
            end
        end
        Rd_En = 1'b0;
    endtask

    task automatic test_collision();
        logic [31:0] exp;
`ifdef SRAM_WR_BYPASS_EN
        exp = 32'hDEAD_BEEF;
`else
        exp = 32'h0;
`endif
        // Different addresses in one cycle: read 5 while writing 8.
        Wr_En = 1'b1; Wr_Addr = 4'd8; Wr_Data = 32'h5555_5555; Wr_Be = 4'hF;
        Rd_En = 1'b1; Rd_Addr = 4'd5;
        tick();
        total++;
        if (Rd_Valid1 !== 1'b1 || Rd_Data1 !== 32'hAA22_CC44) begin
            $display("FAIL indep_ports: got valid=%b data=%h required valid=1 data=aa22cc44",
                     Rd_Valid1, Rd_Data1);
        end else passed++;
        // Same address: addr 7 still holds zero from the clear.
        Wr_Addr = 4'd7; Wr_Data = 32'hDEAD_BEEF; Rd_Addr = 4'd7;
        tick();
        Wr_En = 1'b0; Rd_En = 1'b0;
        total++;
        if (Rd_Data1 !== exp) begin
            $display("FAIL collision_lat1: got %h required %h", Rd_Data1, exp);
        end else passed++;
        tick();
        total++;
        if (Rd_Data2 !== exp) begin
            $display("FAIL collision_lat2: got %h required %h", Rd_Data2, exp);
        end else passed++;
        Rd_En = 1'b1; Rd_Addr = 4'd7;
        tick();
        Rd_En = 1'b1; Rd_Addr = 4'd8;
        total++;
        if (Rd_Data1 !== 32'hDEAD_BEEF) begin
            $display("FAIL collision_after: got %h required deadbeef", Rd_Data1);
        end else passed++;
        tick();
        Rd_En = 1'b0;
        total++;
        if (Rd_Data1 !== 32'h5555_5555) begin
            $display("FAIL indep_write: got %h required 55555555", Rd_Data1);
        end else passed++;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_read();
        int cnt;
        Rd_En = 1'b1; Rd_Addr = 4'd5;
        tick();
        Rd_En = 1'b0; Rst = 1'b0;
        tick();
        total++;
        if (Rd_Valid2 !== 1'b0 || Rd_Data2 !== 32'h0) begin
            $display("FAIL midread_flush: got valid=%b data=%h required valid=0 data=00000000",
                     Rd_Valid2, Rd_Data2);
        end else passed++;
        tick();
        Rst = 1'b1;
        cnt = 0;
        while (Busy2 === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
            total++;
            if (Rd_Valid2 !== 1'b0) begin
                $display("FAIL midread_stale: cycle %0d got valid=%b required 0", cnt, Rd_Valid2);
            end else passed++;
        end
        total++;
        if (cnt !== 16) begin
            $display("FAIL midread_clear_len: got %0d cycles required 16", cnt);
        end else passed++;
    endtask

    initial begin
        total = 0; passed = 0;
        Rst = 1'b0; Wr_En = 1'b0; Wr_Addr = '0; Wr_Be = '0; Wr_Data = '0;
        Rd_En = 1'b0; Rd_Addr = '0;
        test_reset();
        test_mid_clear_reset();
        test_byte_enables();
        test_back_to_back();
        test_collision();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion required completion before 200000");
        $fatal(1, "timeout");
    end

endmodule
